// File: rtl/jtdd_mcu_bridge.sv
// ============================================================================
// Module   : jtdd_mcu_bridge
// Purpose  : Main-CPU to MCU bridge: arbitrated shared-RAM access, control/status
//            registers and main-CPU IRQ. Optional macro: JTDD_MCU_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jtdd_mcu_bridge (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_shared_cs,
   input  logic       cpu_ctrl_cs,
   input  logic [1:0] cpu_AB,
   input  logic       cpu_wrn,
   input  logic [7:0] cpu_dout,
   output logic [7:0] cpu_din,
   output logic       cpu_wait,
   output logic       main_irqn,
   output logic       com_cs,
   input  logic       mcu_ban,
   input  logic [7:0] shared_dout,
   input  logic       mcu_irqmain,
   output logic       mcu_nmi_set,
   output logic       mcu_haltn
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_LATCH  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t     r_state;
   logic [7:0] r_cpu_din;
   logic       r_haltn;
   logic       r_irq_pending;
   logic       r_nmi;
   logic       r_ctrl_cs_d;
   logic       r_irq_d1;
   logic       r_irq_d2;

   logic       w_ctrl_rise;
   logic       w_ctrl_wr;
   logic       w_clr;
   logic       w_irq_set;
   logic       w_tmo_flag;
   logic       w_unused;

   // Register writes act once per select strobe, on its rising edge
   assign w_ctrl_rise = cpu_ctrl_cs & ~r_ctrl_cs_d;
   assign w_ctrl_wr   = w_ctrl_rise & ~cpu_wrn;
   assign w_clr       = w_ctrl_wr & (cpu_AB == 2'd2);
   assign w_irq_set   = r_irq_d1 & ~r_irq_d2;
   assign w_unused    = &{1'b0, cpu_dout[7:1]};

`ifdef JTDD_MCU_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic       r_tmo_flag;
   assign w_tmo_flag = r_tmo_flag;
`else
   assign w_tmo_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cpu_din <= 8'h00;
`ifdef JTDD_MCU_TIMEOUT_EN
         r_tmo_cnt  <= 8'd0;
         r_tmo_flag <= 1'b0;
`endif
      end else begin
`ifdef JTDD_MCU_TIMEOUT_EN
         if (w_clr)
            r_tmo_flag <= 1'b0;
`endif
         // Status read first so a shared-RAM latch in the same clk takes priority
         if (cpu_ctrl_cs && cpu_wrn)
            r_cpu_din <= {5'b0, w_tmo_flag, r_irq_pending, r_haltn};
         case (r_state)
            ST_IDLE: begin
               if (cpu_shared_cs) begin
                  if (mcu_ban) begin
                     r_state <= ST_ACCESS;
                  end else begin
                     r_state <= ST_WAIT;
`ifdef JTDD_MCU_TIMEOUT_EN
                     r_tmo_cnt <= 8'd0;
`endif
                  end
               end
            end
            ST_WAIT: begin
               if (!cpu_shared_cs)
                  r_state <= ST_IDLE;
               else if (mcu_ban)
                  r_state <= ST_ACCESS;
`ifdef JTDD_MCU_TIMEOUT_EN
               else if (r_tmo_cnt == 8'd254) begin
                  r_tmo_cnt  <= 8'd255;
                  r_state    <= ST_DONE;
                  r_cpu_din  <= 8'hFF;
                  r_tmo_flag <= 1'b1;
               end else
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
            end
            ST_ACCESS: begin
               if (!cpu_shared_cs)
                  r_state <= ST_IDLE;
               else if (mcu_ban)
                  r_state <= ST_LATCH;
               else begin
                  r_state <= ST_WAIT;
`ifdef JTDD_MCU_TIMEOUT_EN
                  r_tmo_cnt <= 8'd0;
`endif
               end
            end
            ST_LATCH: begin
               if (!cpu_shared_cs)
                  r_state <= ST_IDLE;
               else begin
                  r_state <= ST_DONE;
                  if (cpu_wrn)
                     r_cpu_din <= shared_dout;
               end
            end
            ST_DONE: begin
               if (!cpu_shared_cs)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_haltn       <= 1'b0;
         r_irq_pending <= 1'b0;
         r_nmi         <= 1'b0;
         r_ctrl_cs_d   <= 1'b0;
         r_irq_d1      <= 1'b0;
         r_irq_d2      <= 1'b0;
      end else begin
         r_ctrl_cs_d <= cpu_ctrl_cs;
         r_irq_d1    <= mcu_irqmain;
         r_irq_d2    <= r_irq_d1;
         r_nmi       <= w_ctrl_wr && (cpu_AB == 2'd1);
         if (w_ctrl_wr && (cpu_AB == 2'd0))
            r_haltn <= cpu_dout[0];
         // A new MCU request beats a simultaneous acknowledge
         if (w_irq_set)
            r_irq_pending <= 1'b1;
         else if (w_clr)
            r_irq_pending <= 1'b0;
      end
   end

   assign cpu_din     = r_cpu_din;
   assign cpu_wait    = cpu_shared_cs && (r_state != ST_DONE);
   assign com_cs      = !rst && cpu_shared_cs && mcu_ban && (r_state == ST_ACCESS);
   assign main_irqn   = ~r_irq_pending;
   assign mcu_nmi_set = r_nmi;
   assign mcu_haltn   = r_haltn;

endmodule

`default_nettype wire
